food_tile_renderer: RTL
=======================

# food_tile_renderer

Reads one food sprite out of the food sprite lookup (`food_layout`) and streams it as pixels. On a start handshake it latches the food type and scans the 16×16 tile in raster order. It drives coordinates into the combinational lookup and emits one registered 2-bit colour per pixel on a valid/ready stream. It sits between the maze tile scheduler, which issues start requests, and the frame-buffer writer, which consumes the pixel stream.

## Interface
- `TILE_SIZE`, default 16: tile edge in pixels. Must be a power of two, ≤ 16.
- `COORD_W`, default 4: coordinate width. Must equal log2 of the lookup's coordinate range (4).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start_valid` in 1: request to render one tile.
- `start_type` in 2: food type, sampled on the start handshake.
- `start_ready` out 1: high only in IDLE.
- `lay_x` out COORD_W: x coordinate driven to the lookup.
- `lay_y` out COORD_W: y coordinate driven to the lookup.
- `lay_type` out 2: latched food type driven to the lookup.
- `lay_value` in 2: combinational colour returned by the lookup.
- `pix_valid` out 1: output pixel valid.
- `pix_ready` in 1: consumer accepts the pixel.
- `pix_value` out 2: colour, 0..3.
- `pix_x` out COORD_W: x coordinate of the pixel on the output.
- `pix_y` out COORD_W: y coordinate of the pixel on the output.
- `pix_last` out 1: marks the final pixel, (TILE_SIZE-1, TILE_SIZE-1).
- `busy` out 1: high in RUN or DRAIN.

## Operation
- **FSM states:** IDLE, RUN, DRAIN.
- **IDLE**
  - `start_ready`=1.
  - On `start_valid`: latch `start_type`, clear scan counters (x=0, y=0), go to RUN.
- **RUN**
  - `lay_x`/`lay_y` equal the scan counters; `lay_type` equals the latched type.
  - Load condition: `load = !pix_valid || pix_ready`.
  - On load, the output register takes `lay_value`, the counters, and `pix_last` = (x==TILE_SIZE-1 && y==TILE_SIZE-1). `pix_valid` is set to 1.
  - Counters advance on load, raster order: x increments; at TILE_SIZE-1, x wraps to 0 and y increments.
  - On the load of the last pixel, go to DRAIN. Counters hold.
- **DRAIN**
  - Hold the output register until `pix_valid && pix_ready`.
  - Then clear `pix_valid` and go to IDLE.
- **Busy rules**
  - `start_valid` while not IDLE is ignored; `start_ready`=0.
  - `start_type` changes mid-tile have no effect.
- **Backpressure:** while `pix_valid && !pix_ready`, all output fields and the counters hold stable.
- **Arithmetic:** counters are COORD_W bits; the wrap compare is against TILE_SIZE-1. The counters themselves never overflow.
- **Reset, any state including mid-tile:** state=IDLE, counters=0, latched type=0. Outputs reset to:
  - `pix_valid`=0, `pix_value`=0, `pix_x`=0, `pix_y`=0, `pix_last`=0
  - `busy`=0
  - `start_ready`=1 in the cycle after reset deasserts.
  - The partial tile is discarded; no further pixels are emitted.

## Timing
- Start handshake in cycle C0 → state RUN in C1.
- First pixel (0,0): `pix_valid`=1 in C2.
- With `pix_ready` held high:
  - One pixel per cycle, C2..C257, 256 beats total.
  - `pix_last` in C257.
  - IDLE with `start_ready`=1 in C258.
  - Minimum start-to-start period: 258 cycles.
- Each `pix_ready`=0 cycle with `pix_valid`=1 delays every later event by exactly one cycle.
- Lookup path: `lay_*` registered → `food_layout` → output register. One combinational lookup per cycle, no extra pipeline stage.

## Structure
- Shared package `food_render_pkg`:
  - state enum `{IDLE, RUN, DRAIN}`
  - `FOOD_TYPE_W`=2
  - `COLOR_W`=2
  - `TILE_SIZE_DEFAULT`=16
- One sub-module `tile_scan_counter`: raster x/y counter with enable, clear, and a last flag. It is reused later by other sprite renderers.
- `food_layout` is not instantiated inside this block; it is connected at the parent.

## Test plan
The bench instantiates `food_layout` on the `lay_*` ports.
1. **Full tile, no backpressure:** type=3, `pix_ready`=1.
   - 256 beats; `pix_last` only on beat 256, at (15,15).
   - Pixel (6,6)=2, (7,7)=3, (0,0)=0, (9,9)=2.
   - `start_ready` returns in C258.
2. **Empty sprite:** type=0. All 256 values are 0.
3. **Random backpressure:** type=2, `pix_ready` 50% random.
   - Output stable while stalled.
   - Sequence identical to the no-stall run.
   - (7,6)=1, (6,7)=2.
4. **Start while busy:** second `start_valid` with type=1 during RUN and during DRAIN.
   - Ignored, `start_ready`=0.
   - The tile completes with type 2 values.
5. **Reset mid-tile:** `rst` at beat 100.
   - Next cycle: `pix_valid`=0, `busy`=0, `start_ready`=1.
   - A new start (type=1) restarts at (0,0); pixel (6,6)=0, (7,7)=2.
6. **Back-to-back:** start held high with alternating types. Each tile begins exactly 258 cycles after the previous start.

Source files
------------

// File: rtl/food_render_pkg.sv
// Shared types and constants for the food sprite renderers.
package food_render_pkg;

    localparam int FOOD_TYPE_W       = 2;
    localparam int COLOR_W           = 2;
    localparam int TILE_SIZE_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } render_state_e;

    // A stream register may take a new beat when it is empty or its beat is leaving.
    function automatic logic stream_load(input logic valid, input logic ready);
        return !valid || ready;
    endfunction

endpackage

// File: rtl/food_layout.sv
// Food sprite lookup: combinational colour for (type, x, y) on a 16x16 tile.
// Shapes are concentric discs around the tile centre (7.5, 7.5), measured in
// doubled coordinates so the centre lands on an integer.
//   type 0: empty
//   type 1: small dot, colour 2
//   type 2: fruit disc split on the diagonal (1 above, 2 on/below)
//   type 3: power pellet, core 3 with ring 2
module food_layout
    import food_render_pkg::*;
(
    input  logic [3:0]             x_i,
    input  logic [3:0]             y_i,
    input  logic [FOOD_TYPE_W-1:0] type_i,
    output logic [COLOR_W-1:0]     value_o
);

    logic [4:0] x2, y2;
    logic [4:0] adx, ady;
    logic [9:0] r2;

    assign x2  = {x_i, 1'b0};
    assign y2  = {y_i, 1'b0};
    assign adx = x_i[3] ? (x2 - 5'd15) : (5'd15 - x2);
    assign ady = y_i[3] ? (y2 - 5'd15) : (5'd15 - y2);
    assign r2  = 10'(adx) * 10'(adx) + 10'(ady) * 10'(ady);

    // Shape selection by squared distance from the tile centre.
    always_comb begin
        value_o = '0;
        case (type_i)
            2'd1: begin
                if (r2 <= 10'd2) value_o = 2'd2;
            end
            2'd2: begin
                if (r2 <= 10'd50) value_o = (x_i > y_i) ? 2'd1 : 2'd2;
            end
            2'd3: begin
                if (r2 <= 10'd8)        value_o = 2'd3;
                else if (r2 <= 10'd100) value_o = 2'd2;
            end
            default: value_o = '0;
        endcase
    end

endmodule

// File: rtl/tile_scan_counter.sv
// Raster-order x/y scan counter for a square sprite tile.
// x runs fastest; last_o flags the bottom-right pixel. Reused by other sprite renderers.
module tile_scan_counter #(
    parameter int TILE_SIZE = 16,
    parameter int COORD_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               en_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               last_o
);

    localparam logic [COORD_W-1:0] MAX_COORD = COORD_W'(TILE_SIZE - 1);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;

    // Next scan position: clear wins over advance; wrap is against the tile edge, not the counter width.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (en_i) begin
            if (x_q == MAX_COORD) begin
                x_d = '0;
                y_d = (y_q == MAX_COORD) ? '0 : y_q + COORD_W'(1);
            end else begin
                x_d = x_q + COORD_W'(1);
            end
        end
    end

    // Scan position registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == MAX_COORD) && (y_q == MAX_COORD);

endmodule

// File: rtl/food_tile_renderer.sv
// Streams one food sprite tile as 2-bit pixels in raster order.
// The lookup sits outside this block on the lay_* ports; its colour is
// captured straight into the output register, one lookup per cycle.
module food_tile_renderer
    import food_render_pkg::*;
#(
    parameter int TILE_SIZE = TILE_SIZE_DEFAULT,
    parameter int COORD_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_valid,
    input  logic [FOOD_TYPE_W-1:0] start_type,
    output logic                   start_ready,
    output logic [COORD_W-1:0]     lay_x,
    output logic [COORD_W-1:0]     lay_y,
    output logic [FOOD_TYPE_W-1:0] lay_type,
    input  logic [COLOR_W-1:0]     lay_value,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [COLOR_W-1:0]     pix_value,
    output logic [COORD_W-1:0]     pix_x,
    output logic [COORD_W-1:0]     pix_y,
    output logic                   pix_last,
    output logic                   busy
);

    render_state_e          state_q;
    logic [FOOD_TYPE_W-1:0] type_q;
    logic                   pix_valid_q;
    logic [COLOR_W-1:0]     pix_value_q;
    logic [COORD_W-1:0]     pix_x_q;
    logic [COORD_W-1:0]     pix_y_q;
    logic                   pix_last_q;

    logic               load;
    logic               cnt_clr;
    logic               cnt_en;
    logic               cnt_last;
    logic [COORD_W-1:0] cnt_x;
    logic [COORD_W-1:0] cnt_y;

    assign load    = stream_load(pix_valid_q, pix_ready);
    assign cnt_clr = (state_q == IDLE) && start_valid;
    // The counter parks on the last pixel; DRAIN only waits for the final beat to leave.
    assign cnt_en  = (state_q == RUN) && load && !cnt_last;

    tile_scan_counter #(
        .TILE_SIZE (TILE_SIZE),
        .COORD_W   (COORD_W)
    ) u_scan (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .x_o    (cnt_x),
        .y_o    (cnt_y),
        .last_o (cnt_last)
    );

    // Sequencer and registered pixel output; a stalled beat holds every field.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            type_q      <= '0;
            pix_valid_q <= 1'b0;
            pix_value_q <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        type_q  <= start_type;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (load) begin
                        pix_valid_q <= 1'b1;
                        pix_value_q <= lay_value;
                        pix_x_q     <= cnt_x;
                        pix_y_q     <= cnt_y;
                        pix_last_q  <= cnt_last;
                        if (cnt_last) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pix_valid_q && pix_ready) begin
                        pix_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign lay_x       = cnt_x;
    assign lay_y       = cnt_y;
    assign lay_type    = type_q;
    assign pix_valid   = pix_valid_q;
    assign pix_value   = pix_value_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_last    = pix_last_q;

endmodule
